// File: rtl/conv_stripe_sequencer.sv
// conv_stripe_sequencer: loop sequencer for one conv layer's feature/weight stripe fetch traffic.
// Ports: clk/rst_n (async active-low); start + cfg_* latched when idle;
//   dat_ch_go/wt_ch_go gate the two request channels; feat_req_* / wt_req_* are vld/rdy beat
//   requests; wout_loop_end_comb / wt_last_comb are per-group end-of-use pulses; busy/done status.
module conv_stripe_sequencer #(
  parameter int CNT_W = 16,
  parameter int GRP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_chin_kykx,
  input  logic [CNT_W-1:0] cfg_wout,
  input  logic [CNT_W-1:0] cfg_hout,
  input  logic [GRP_W-1:0] cfg_cout_grp,
  input  logic             dat_ch_go,
  input  logic             wt_ch_go,
  output logic             feat_req_vld,
  input  logic             feat_req_rdy,
  output logic             feat_req_last,
  output logic             wt_req_vld,
  input  logic             wt_req_rdy,
  output logic             wout_loop_end_comb,
  output logic             wt_last_comb,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] chin_max_q, chin_max_d, wout_max_q, wout_max_d, hout_max_q, hout_max_d;
  logic [GRP_W-1:0] grp_max_q, grp_max_d;
  logic [CNT_W-1:0] wck_q, wck_d, wh_q, wh_d;
  logic [GRP_W-1:0] wg_q, wg_d;
  logic [CNT_W-1:0] dck_q, dck_d, dw_q, dw_d, dh_q, dh_d;
  logic [GRP_W-1:0] dg_q, dg_d;
  logic             wt_act_q, wt_act_d, dat_act_q, dat_act_d;
  logic             cfg_zero, wt_hs, dat_hs;
  logic             wck_end, wg_end, wh_end, dck_end, dw_end, dg_end, dh_end;
  assign cfg_zero = (cfg_chin_kykx == '0) | (cfg_wout == '0) | (cfg_hout == '0) | (cfg_cout_grp == '0);
  assign wck_end  = wck_q == chin_max_q;
  assign wg_end   = wg_q == grp_max_q;
  assign wh_end   = wh_q == hout_max_q;
  assign dck_end  = dck_q == chin_max_q;
  assign dw_end   = dw_q == wout_max_q;
  assign dg_end   = dg_q == grp_max_q;
  assign dh_end   = dh_q == hout_max_q;
  assign wt_req_vld         = wt_act_q & wt_ch_go;
  assign feat_req_vld       = dat_act_q & dat_ch_go;
  assign wt_hs              = wt_req_vld & wt_req_rdy;
  assign dat_hs             = feat_req_vld & feat_req_rdy;
  // Gated by dat_active so the idle max==0 compare never shows up as a stray last flag.
  assign feat_req_last      = dat_act_q & dck_end;
  assign wt_last_comb       = wt_hs & wck_end;
  assign wout_loop_end_comb = dat_hs & dck_end & dw_end;
  assign busy               = state_q == S_RUN;
  assign done               = state_q == S_FIN;
  always_comb begin
    state_d    = state_q;
    chin_max_d = chin_max_q;
    wout_max_d = wout_max_q;
    hout_max_d = hout_max_q;
    grp_max_d  = grp_max_q;
    wck_d      = wck_q;
    wg_d       = wg_q;
    wh_d       = wh_q;
    dck_d      = dck_q;
    dw_d       = dw_q;
    dg_d       = dg_q;
    dh_d       = dh_q;
    wt_act_d   = wt_act_q;
    dat_act_d  = dat_act_q;
    if (state_q != S_RUN && start) begin
      chin_max_d = cfg_chin_kykx - CNT_W'(1);
      wout_max_d = cfg_wout - CNT_W'(1);
      hout_max_d = cfg_hout - CNT_W'(1);
      grp_max_d  = cfg_cout_grp - GRP_W'(1);
      wck_d      = '0;
      wg_d       = '0;
      wh_d       = '0;
      dck_d      = '0;
      dw_d       = '0;
      dg_d       = '0;
      dh_d       = '0;
      wt_act_d   = !cfg_zero;
      dat_act_d  = !cfg_zero;
      state_d    = cfg_zero ? S_FIN : S_RUN;
    end else if (state_q == S_RUN) begin
      // Weight odometer: wck -> wg -> wh.
      if (wt_hs) begin
        wck_d = wck_end ? '0 : wck_q + CNT_W'(1);
        if (wck_end) begin
          wg_d = wg_end ? '0 : wg_q + GRP_W'(1);
          if (wg_end) begin
            wh_d = wh_end ? '0 : wh_q + CNT_W'(1);
            wt_act_d = !wh_end;
          end
        end
      end
      // Data odometer: dck -> dw -> dg -> dh.
      if (dat_hs) begin
        dck_d = dck_end ? '0 : dck_q + CNT_W'(1);
        if (dck_end) begin
          dw_d = dw_end ? '0 : dw_q + CNT_W'(1);
          if (dw_end) begin
            dg_d = dg_end ? '0 : dg_q + GRP_W'(1);
            if (dg_end) begin
              dh_d = dh_end ? '0 : dh_q + CNT_W'(1);
              dat_act_d = !dh_end;
            end
          end
        end
      end
      state_d = (!wt_act_q && !dat_act_q) ? S_FIN : S_RUN;
    end else if (state_q == S_FIN) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      chin_max_q <= '0;
      wout_max_q <= '0;
      hout_max_q <= '0;
      grp_max_q  <= '0;
      wck_q      <= '0;
      wg_q       <= '0;
      wh_q       <= '0;
      dck_q      <= '0;
      dw_q       <= '0;
      dg_q       <= '0;
      dh_q       <= '0;
      wt_act_q   <= 1'b0;
      dat_act_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      chin_max_q <= chin_max_d;
      wout_max_q <= wout_max_d;
      hout_max_q <= hout_max_d;
      grp_max_q  <= grp_max_d;
      wck_q      <= wck_d;
      wg_q       <= wg_d;
      wh_q       <= wh_d;
      dck_q      <= dck_d;
      dw_q       <= dw_d;
      dg_q       <= dg_d;
      dh_q       <= dh_d;
      wt_act_q   <= wt_act_d;
      dat_act_q  <= dat_act_d;
    end
  end
endmodule

// File: tb/tb_conv_stripe_sequencer.sv
// tb_conv_stripe_sequencer: scoreboard bench for conv_stripe_sequencer.
module tb_conv_stripe_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] cfg_chin_kykx = '0, cfg_wout = '0, cfg_hout = '0;
  logic [7:0]  cfg_cout_grp = '0;
  logic        dat_ch_go = 1'b1, wt_ch_go = 1'b1, feat_req_rdy = 1'b1, wt_req_rdy = 1'b1;
  logic        feat_req_vld, feat_req_last, wt_req_vld, wout_loop_end_comb, wt_last_comb, busy, done;
  logic        bp_mode = 1'b0;
  logic [1:0]  fq[$];
  logic        wq[$];
  int          n_cmp = 0, n_bad = 0, feat_cnt = 0, wt_cnt = 0, done_cnt = 0, both_cnt = 0;
  conv_stripe_sequencer #(.CNT_W(16), .GRP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_chin_kykx(cfg_chin_kykx), .cfg_wout(cfg_wout), .cfg_hout(cfg_hout), .cfg_cout_grp(cfg_cout_grp),
    .dat_ch_go(dat_ch_go), .wt_ch_go(wt_ch_go),
    .feat_req_vld(feat_req_vld), .feat_req_rdy(feat_req_rdy), .feat_req_last(feat_req_last),
    .wt_req_vld(wt_req_vld), .wt_req_rdy(wt_req_rdy),
    .wout_loop_end_comb(wout_loop_end_comb), .wt_last_comb(wt_last_comb),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    feat_req_rdy = bp_mode ? ~feat_req_rdy : 1'b1;
  end
  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (feat_req_vld && feat_req_rdy) begin
        feat_cnt++;
        n_cmp++;
        if (fq.size() == 0) begin
          n_bad++;
          $display("FAIL feat_beat: unexpected beat %0d", feat_cnt);
        end else begin
          logic [1:0] e;
          e = fq.pop_front();
          n_cmp--;
          chk("feat_last_wend", int'({feat_req_last, wout_loop_end_comb}), int'(e));
        end
      end
      if (wt_req_vld && wt_req_rdy) begin
        wt_cnt++;
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL wt_beat: unexpected beat %0d", wt_cnt);
        end else begin
          logic e;
          e = wq.pop_front();
          n_cmp--;
          chk("wt_last", int'(wt_last_comb), int'(e));
        end
      end
      if (wt_last_comb && wout_loop_end_comb) both_cnt++;
      if (done) done_cnt++;
    end
  end
  task automatic launch(input int ch, input int w, input int h, input int g);
    for (int k = 0; k < ch * w * g * h; k++)
      fq.push_back({k % ch == ch - 1, k % (ch * w) == ch * w - 1});
    for (int k = 0; k < ch * g * h; k++)
      wq.push_back(k % ch == ch - 1);
    @(posedge clk);
    #1;
    cfg_chin_kykx = 16'(ch);
    cfg_wout = 16'(w);
    cfg_hout = 16'(h);
    cfg_cout_grp = 8'(g);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_chin_kykx = '0;
    cfg_wout = '0;
  endtask
  task automatic finish_layer(input string name, input int f0, input int w0, input int nf, input int nw);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    chk({name, "_feat_beats"}, feat_cnt - f0, nf);
    chk({name, "_wt_beats"}, wt_cnt - w0, nw);
    chk({name, "_queues_left"}, fq.size() + wq.size(), 0);
    chk({name, "_busy_after"}, int'(busy), 0);
  endtask
  initial begin
    int f0, w0, d0, b0, bad;
    #1;
    chk("reset_outputs", int'({feat_req_vld, feat_req_last, wt_req_vld, wout_loop_end_comb, wt_last_comb, busy, done}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_outputs", int'({feat_req_vld, feat_req_last, wt_req_vld, busy, done}), 0);
    f0 = feat_cnt; w0 = wt_cnt;
    launch(3, 2, 1, 2);
    chk("basic_busy", int'(busy), 1);
    repeat (3) @(posedge clk);
    #1;
    cfg_chin_kykx = 16'd1; cfg_wout = 16'd1; cfg_hout = 16'd1; cfg_cout_grp = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_layer("basic", f0, w0, 12, 6);
    bp_mode = 1'b1;
    f0 = feat_cnt; w0 = wt_cnt;
    launch(3, 2, 1, 2);
    finish_layer("backpressure", f0, w0, 12, 6);
    bp_mode = 1'b0;
    f0 = feat_cnt; w0 = wt_cnt;
    launch(4, 2, 1, 1);
    for (int i = 0; i < 50 && feat_cnt - f0 < 2; i++) @(posedge clk);
    #1;
    dat_ch_go = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (feat_req_vld) bad = 1;
    end
    chk("gate_vld_low", bad, 0);
    chk("gate_frozen_beats", feat_cnt - f0, 2);
    chk("gate_last_flag", int'(feat_req_last), 0);
    @(posedge clk);
    #1 dat_ch_go = 1'b1;
    finish_layer("gate", f0, w0, 8, 4);
    f0 = feat_cnt; w0 = wt_cnt; b0 = both_cnt;
    launch(2, 1, 1, 1);
    finish_layer("simul", f0, w0, 2, 2);
    chk("simul_both_pulses", both_cnt - b0, 1);
    f0 = feat_cnt; w0 = wt_cnt;
    launch(1, 1, 2, 1);
    chk("boundary_last_const", int'(feat_req_last), 1);
    finish_layer("boundary", f0, w0, 2, 2);
    f0 = feat_cnt; w0 = wt_cnt; d0 = done_cnt;
    @(posedge clk);
    #1;
    cfg_chin_kykx = 16'd2; cfg_wout = 16'd0; cfg_hout = 16'd2; cfg_cout_grp = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("zero_done_next", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    chk("zero_vld", int'({feat_req_vld, wt_req_vld}), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_done_count", done_cnt - d0, 1);
    chk("zero_beats", (feat_cnt - f0) + (wt_cnt - w0), 0);
    launch(3, 2, 2, 2);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs", int'({feat_req_vld, feat_req_last, wt_req_vld, busy, done}), 0);
    fq.delete();
    wq.delete();
    d0 = done_cnt; f0 = feat_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_beats", feat_cnt - f0, 0);
    chk("rst_idle", int'({busy, feat_req_vld, wt_req_vld}), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_stripe_sequencer.md
Name: conv_stripe_sequencer

Overview:
Loop sequencer for one convolution layer's stripe traffic. It generates feature-fetch and weight-fetch request beats in the loop order h → cout_group → (w) → chin_kykx. It produces the per-group end-of-use pulses consumed by the stripe flow-control block, and obeys that block's dat_ch_go / wt_ch_go gating. It sits between the layer-start logic and the feature/weight buffer read engines.

Parameters:
CNT_W, 16, width of every loop counter and config field
GRP_W, 8, width of the cout-group counter/config

Ports:
clk  input  1  clock
rst_n  input  1  reset
start  input  1  one-cycle layer start pulse
cfg_chin_kykx  input  CNT_W  beats per output pixel (CHin·Ky·Kx / beat width)
cfg_wout  input  CNT_W  output pixels per row
cfg_hout  input  CNT_W  output rows
cfg_cout_grp  input  GRP_W  weight groups per row
dat_ch_go  input  1  data channel permission from flow control
wt_ch_go  input  1  weight channel permission from flow control
feat_req_vld  output  1  feature beat request valid
feat_req_rdy  input  1  feature read engine accepts beat
feat_req_last  output  1  last beat of current pixel (CHinKyKx_max_now_comb)
wt_req_vld  output  1  weight beat request valid
wt_req_rdy  input  1  weight read engine accepts beat
wout_loop_end_comb  output  1  data finished with current wt group (pulse)
wt_last_comb  output  1  last weight beat of a group accepted (pulse)
busy  output  1  layer in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; all counters 0; both channels idle.
- start while busy=0: latch all cfg_* fields. busy=1 from the next cycle. Requests may assert from that cycle. start while busy=1 is ignored.
- Zero config: if any latched field is 0, issue no requests. Assert done one cycle after start; busy stays 0.
- Weight channel counters: wck (0..chin_kykx-1), wg (0..cout_grp-1), wh (0..hout-1).
  - wt_req_vld = wt_active & wt_ch_go (combinational).
  - Each wt handshake advances wck. On wrap, advance wg; on wg wrap, advance wh.
  - wt_last_comb = wt handshake & wck==chin_kykx-1.
  - wt_active clears after the handshake with all three counters at max.
- Data channel counters: dck, dw (0..wout-1), dg, dh.
  - feat_req_vld = dat_active & dat_ch_go (combinational).
  - feat_req_last = dck==chin_kykx-1, valid whenever feat_req_vld=1.
  - Each feature handshake advances dck → dw → dg → dh (odometer order).
  - wout_loop_end_comb = feature handshake & dck max & dw max.
  - dat_active clears after the handshake with all counters at max.
- Downstream read engines tolerate vld withdrawal caused by go deassertion. The sequencer never changes counters without a handshake.
- Data and weight channels advance independently, in the same cycle if both handshake. Ordering between them is enforced solely by dat_ch_go / wt_ch_go.
- done: pulses 1 cycle in the cycle after both channels are inactive. busy falls in that same cycle.
- rst_n assertion mid-layer: immediate return to reset state; no done pulse.
- Counter arithmetic is unsigned, width CNT_W/GRP_W. Compare against cfg-1 computed at latch time; there is no overflow path.
- A chin_kykx=1 config makes every beat both first and last: feat_req_last is constant 1, and wt_last_comb fires on every weight handshake.

Test Plan:
- Basic: chin_kykx=3, wout=2, hout=1, cout_grp=2, go and rdy tied 1. Required: 6 wt beats with wt_last_comb on beats 3 and 6; 12 feature beats with feat_req_last on every 3rd beat; wout_loop_end_comb on feature beats 6 and 12; one done pulse; busy back to 0.
- Backpressure: same config, feat_req_rdy toggling 1/0 each cycle. Required: counts and pulse positions identical to Basic; no beat lost or duplicated.
- Go gating: hold dat_ch_go=0 for 10 cycles mid-pixel. Required: feat_req_vld=0 during the hold; counters frozen; traffic resumes at the same dck.
- Simultaneous events: config chosen so wt_last_comb and wout_loop_end_comb fire in the same cycle. Required: both pulses high together.
- Boundary: chin_kykx=1, wout=1, hout=2, cout_grp=1. Required: feat_req_last always 1; 2 feature beats; 2 weight beats; 2 pulses on each end signal.
- Corner cases: cfg_wout=0 → no requests and done 1 cycle after start. Second start while busy → ignored. rst_n pulse mid-layer → all outputs 0 and no done.
